// File: rtl/mod_n_time_counter.sv
// Modulo-N time-digit counter: cascade count up/down, preset load, press-and-hold adjust
// with auto-repeat, binary + BCD outputs and a one-cycle wrap carry for the next stage.
module mod_n_time_counter #(
  parameter int WIDTH         = 6,
  parameter int MODULUS       = 60,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             enable,
  input  logic             adjust,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             carry,
  output logic             adjusting
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);
  localparam logic [TW-1:0]    T_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    T_PERIOD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            adjust_prev;

  logic             step;
  logic             at_wrap;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] nxt;
  logic             carry_n;
  logic [3:0]       tens_n;
  logic [3:0]       ones_n;

  always_comb begin
    step = 1'b0;
    case (state)
      IDLE:    step = adjust & ~adjust_prev;
      HOLD:    step = adjust & (timer == T_DELAY);
      REPEAT:  step = adjust & (timer == T_PERIOD);
      default: step = 1'b0;
    endcase

    at_wrap = down ? (count == '0) : (count == TOP);
    if (down) stepped = (count == '0) ? TOP : count - WIDTH'(1);
    else      stepped = (count == TOP) ? '0 : count + WIDTH'(1);

    // Only a cascade tick can produce carry; load and adjust swallow a coincident tick.
    nxt     = count;
    carry_n = 1'b0;
    if (load)        nxt = (data_in > TOP) ? TOP : data_in;
    else if (step)   nxt = stepped;
    else if (enable) begin
      nxt     = stepped;
      carry_n = at_wrap;
    end

    tens_n = 4'(32'(nxt) / 32'd10);
    ones_n = 4'(32'(nxt) % 32'd10);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      tens        <= '0;
      ones        <= '0;
      carry       <= 1'b0;
      state       <= IDLE;
      timer       <= '0;
      adjust_prev <= 1'b1;  // a button held through reset must be released before it steps
      adjusting   <= 1'b0;
    end else begin
      count       <= nxt;
      tens        <= tens_n;
      ones        <= ones_n;
      carry       <= carry_n;
      adjust_prev <= adjust;
      // FSM timing runs regardless of whether load overrode the step.
      case (state)
        IDLE: begin
          timer <= '0;
          if (adjust && !adjust_prev) begin
            state     <= HOLD;
            adjusting <= 1'b1;
          end
        end
        HOLD: begin
          if (!adjust) begin
            state     <= IDLE;
            adjusting <= 1'b0;
            timer     <= '0;
          end else if (timer == T_DELAY) begin
            state <= REPEAT;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          if (!adjust) begin
            state     <= IDLE;
            adjusting <= 1'b0;
            timer     <= '0;
          end else if (timer == T_PERIOD) begin
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          adjusting <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_n_time_counter.sv
// Directed bench for mod_n_time_counter (60-count, short repeat timing).
module tb_mod_n_time_counter;
  logic       clock = 1'b0;
  logic       reset, load, enable, adjust, down;
  logic [5:0] data_in;
  logic [5:0] count;
  logic [3:0] tens, ones;
  logic       carry, adjusting;

  int n_cmp = 0;
  int n_bad = 0;

  mod_n_time_counter #(.WIDTH(6), .MODULUS(60), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .load(load), .enable(enable),
    .adjust(adjust), .down(down), .count(count), .tens(tens), .ones(ones),
    .carry(carry), .adjusting(adjusting)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; enable = 1'b0; adjust = 1'b0; down = 1'b0; data_in = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if (count !== 6'd0 || tens !== 4'd0 || ones !== 4'd0 || carry !== 1'b0 || adjusting !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: count=%0d tens=%0d ones=%0d carry=%b adj=%b, want 0 0 0 0 0",
               count, tens, ones, carry, adjusting);
    end
  endtask

  task automatic test_count_up();
    enable = 1'b1; down = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      int e;
      e = i % 60;
      tick();
      n_cmp++;
      if (count !== 6'(e) || tens !== 4'(e / 10) || ones !== 4'(e % 10) || carry !== (i == 60)) begin
        n_bad++;
        $display("FAIL count_up[%0d]: count=%0d %0d/%0d carry=%b, want %0d %0d/%0d carry=%b",
                 i, count, tens, ones, carry, e, e / 10, e % 10, (i == 60));
      end
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (count !== 6'd0 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL count_up_hold: count=%0d carry=%b, want 0 0", count, carry);
    end
  endtask

  task automatic test_count_down();
    enable = 1'b1; down = 1'b1;
    tick();
    n_cmp++;
    if (count !== 6'd59 || tens !== 4'd5 || ones !== 4'd9 || carry !== 1'b1) begin
      n_bad++;
      $display("FAIL borrow: count=%0d %0d/%0d carry=%b, want 59 5/9 1", count, tens, ones, carry);
    end
    enable = 1'b0; down = 1'b0;
    tick();
    n_cmp++;
    if (count !== 6'd59 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL borrow_pulse: count=%0d carry=%b, want 59 0", count, carry);
    end
  endtask

  task automatic test_load();
    load = 1'b1; data_in = 6'd45; enable = 1'b1;
    tick();
    n_cmp++;
    if (count !== 6'd45 || tens !== 4'd4 || ones !== 4'd5 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL load45: count=%0d %0d/%0d carry=%b, want 45 4/5 0", count, tens, ones, carry);
    end
    data_in = 6'd63; enable = 1'b0;
    tick();
    n_cmp++;
    if (count !== 6'd59 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL load_clamp: count=%0d carry=%b, want 59 0", count, carry);
    end
    load = 1'b0;
  endtask

  task automatic test_adjust();
    int e;
    load = 1'b1; data_in = 6'd10;
    tick();
    load = 1'b0;
    e = 10;
    adjust = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0 || k == 8 || k == 11 || k == 14 || k == 17) e++;
      n_cmp++;
      if (count !== 6'(e) || adjusting !== 1'b1 || carry !== 1'b0) begin
        n_bad++;
        $display("FAIL adjust[t0+%0d]: count=%0d adj=%b carry=%b, want %0d 1 0",
                 k, count, adjusting, carry, e);
      end
    end
    adjust = 1'b0;
    tick();
    n_cmp++;
    if (count !== 6'd15 || adjusting !== 1'b0 || tens !== 4'd1 || ones !== 4'd5) begin
      n_bad++;
      $display("FAIL adjust_release: count=%0d adj=%b %0d/%0d, want 15 0 1/5", count, adjusting, tens, ones);
    end
  endtask

  task automatic test_collision();
    load = 1'b1; data_in = 6'd59;
    tick();
    data_in = 6'd7; enable = 1'b1; adjust = 1'b1;
    tick();
    n_cmp++;
    if (count !== 6'd7 || carry !== 1'b0 || adjusting !== 1'b1) begin
      n_bad++;
      $display("FAIL load_over_all: count=%0d carry=%b adj=%b, want 7 0 1", count, carry, adjusting);
    end
    adjust = 1'b0; enable = 1'b0; data_in = 6'd59;
    tick();
    load = 1'b0; adjust = 1'b1; enable = 1'b1;
    tick();
    n_cmp++;
    if (count !== 6'd0 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL adjust_over_enable: count=%0d carry=%b, want 0 0", count, carry);
    end
    adjust = 1'b0; enable = 1'b0;
    tick();
    down = 1'b1; adjust = 1'b1;
    tick();
    n_cmp++;
    if (count !== 6'd59 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL adjust_down_wrap: count=%0d carry=%b, want 59 0", count, carry);
    end
    adjust = 1'b0; down = 1'b0;
    tick();
    load = 1'b1; data_in = 6'd0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_mid_reset();
    adjust = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    n_cmp++;
    if (count !== 6'd3 || adjusting !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: count=%0d adj=%b, want 3 1", count, adjusting);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (count !== 6'd0 || adjusting !== 1'b0 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: count=%0d adj=%b carry=%b, want 0 0 0", count, adjusting, carry);
    end
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (count !== 6'd0 || adjusting !== 1'b0) begin
      n_bad++;
      $display("FAIL held_after_reset: count=%0d adj=%b, want 0 0", count, adjusting);
    end
    adjust = 1'b0;
    tick();
    adjust = 1'b1;
    tick();
    n_cmp++;
    if (count !== 6'd1 || adjusting !== 1'b1) begin
      n_bad++;
      $display("FAIL repress: count=%0d adj=%b, want 1 1", count, adjusting);
    end
    adjust = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_adjust();
    test_collision();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
